// File: rtl/control_store_uop_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_store_uop_seq_if
//  Description : Instruction-in / micro-op-out handshake bundle for the
//                control-store micro-op sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_store_uop_seq_if #(
  parameter int CS_WIDTH = 64,
  parameter int UOP_W    = 2
);

  // Upstream instruction channel
  logic                in_valid;
  logic [CS_WIDTH-1:0] in_cs;
  logic [UOP_W-1:0]    in_last_idx;
  logic                in_ready;

  // Downstream micro-op channel
  logic                out_valid;
  logic [CS_WIDTH-1:0] out_cs;
  logic [UOP_W-1:0]    out_uop_idx;
  logic                out_first;
  logic                out_last;
  logic                out_ready;

  // Environment side: supplies instructions and consumes micro-ops
  modport master (
    output in_valid, in_cs, in_last_idx, out_ready,
    input  in_ready, out_valid, out_cs, out_uop_idx, out_first, out_last
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_cs, in_last_idx, out_ready,
    output in_ready, out_valid, out_cs, out_uop_idx, out_first, out_last
  );

endinterface
`default_nettype wire

// File: rtl/control_store_uop_seq.sv
`default_nettype none
// ============================================================================
//  Module      : control_store_uop_seq
//  Description : Holds one control-store line and issues its micro-ops
//                (index 0 .. last) downstream with valid/ready handshakes.
//                Back-to-back instructions are accepted on the last uop's
//                transfer so no idle bubble appears between instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_store_uop_seq #(
  parameter int CS_WIDTH = 64,
  parameter int UOP_W    = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              flush,
  control_store_uop_seq_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              state_q,     state_d;
  logic [CS_WIDTH-1:0] cs_q,        cs_d;
  logic [UOP_W-1:0]    last_idx_q,  last_idx_d;
  logic [UOP_W-1:0]    idx_q,       idx_d;
  logic                out_valid_q, out_valid_d;
  logic                out_first_q, out_first_d;
  logic                out_last_q,  out_last_d;

  logic                take_out;
  logic                take_in;
  logic                in_ready;
  logic [UOP_W-1:0]    idx_inc;

  // Handshake qualifiers; in_ready opens in IDLE or when the last uop leaves
  always_comb begin
    take_out = out_valid_q && bus.out_ready;
    in_ready = !reset && !flush &&
               ((state_q == ST_IDLE) || (take_out && out_last_q));
    take_in  = bus.in_valid && in_ready;
    idx_inc  = idx_q + UOP_W'(1);
  end

  // Next-state and next-output computation; flush beats both transfers
  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    if (flush) begin
      // Line and index are kept; they are don't-care while nothing is valid
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (take_in) begin
      state_d     = ST_ISSUE;
      cs_d        = bus.in_cs;
      last_idx_d  = bus.in_last_idx;
      idx_d       = '0;
      out_valid_d = 1'b1;
      out_first_d = 1'b1;
      out_last_d  = (bus.in_last_idx == '0);
    end else if (take_out) begin
      if (out_last_q) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        idx_d       = idx_inc;
        out_first_d = 1'b0;
        out_last_d  = (idx_inc == last_idx_q);
      end
    end
  end

  // Sequencer state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cs_q        <= '0;
      last_idx_q  <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      last_idx_q  <= last_idx_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_cs      = cs_q;
  assign bus.out_uop_idx = idx_q;
  assign bus.out_first   = out_first_q;
  assign bus.out_last    = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_control_store_uop_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_store_uop_seq
//  Description : Scoreboard bench for control_store_uop_seq. Every accepted
//                instruction expands into its expected uops in a queue; the
//                head of the queue is what the DUT must present each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_store_uop_seq;

  localparam int CS_WIDTH = 64;
  localparam int UOP_W    = 2;

  typedef struct packed {
    logic [CS_WIDTH-1:0] cs;
    logic [UOP_W-1:0]    idx;
    logic                first;
    logic                last;
  } uop_t;

  logic clk;
  logic reset;
  logic flush;

  control_store_uop_seq_if #(.CS_WIDTH(CS_WIDTH), .UOP_W(UOP_W)) bus ();

  control_store_uop_seq #(.CS_WIDTH(CS_WIDTH), .UOP_W(UOP_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  uop_t sb_q[$];
  logic prev_rst = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare outputs against the scoreboard head, then advance the model
  always @(negedge clk) begin
    uop_t h;
    logic exp_valid;
    logic exp_ready;
    exp_valid = (sb_q.size() != 0);
    h         = exp_valid ? sb_q[0] : '0;
    exp_ready = !reset && !flush && (!exp_valid || (bus.out_ready && h.last));

    check_eq("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    check_eq("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    if (exp_valid) begin
      check_eq("out_cs", bus.out_cs, h.cs);
      check_eq("out_uop_idx", 64'(bus.out_uop_idx), 64'(h.idx));
      check_eq("out_first", 64'(bus.out_first), 64'(h.first));
      check_eq("out_last", 64'(bus.out_last), 64'(h.last));
    end else begin
      check_eq("out_first_idle", 64'(bus.out_first), 64'd0);
      check_eq("out_last_idle", 64'(bus.out_last), 64'd0);
    end
    if (prev_rst) begin
      check_eq("rst_out_cs", bus.out_cs, 64'd0);
      check_eq("rst_out_idx", 64'(bus.out_uop_idx), 64'd0);
    end

    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (exp_valid && bus.out_ready) void'(sb_q.pop_front());
      if (bus.in_valid && exp_ready) begin
        for (int i = 0; i <= int'(bus.in_last_idx); i++) begin
          uop_t e;
          e.cs    = bus.in_cs;
          e.idx   = UOP_W'(i);
          e.first = (i == 0);
          e.last  = (i == int'(bus.in_last_idx));
          sb_q.push_back(e);
        end
      end
    end
    prev_rst = reset;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [CS_WIDTH-1:0] cs, input logic [UOP_W-1:0] last_idx);
    bus.in_valid    = 1'b1;
    bus.in_cs       = cs;
    bus.in_last_idx = last_idx;
  endtask

  initial begin
    reset           = 1'b1;
    flush           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_cs       = '0;
    bus.in_last_idx = '0;
    bus.out_ready   = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;

    // Single uop
    present(64'hA5, 2'd0);
    cyc();
    bus.in_valid = 1'b0;
    repeat (2) cyc();

    // Two uops, same line on both
    present(64'hC3C3_0000_1111_2222, 2'd1);
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();

    // Four uops with backpressure held at idx 1
    present(64'h1234, 2'd3);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    bus.out_ready = 1'b1;
    repeat (4) cyc();

    // Back-to-back: B presented at A's last-uop transfer
    present(64'hAA, 2'd1);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    present(64'h2, 2'd0);
    cyc();
    bus.in_valid = 1'b0;
    repeat (2) cyc();

    // Flush at idx 2 of 4 with a new instruction waiting
    present(64'h55, 2'd3);
    cyc();
    bus.in_valid = 1'b0;
    repeat (2) cyc();
    flush = 1'b1;
    present(64'h77, 2'd0);
    cyc();
    flush = 1'b0;
    cyc();
    bus.in_valid = 1'b0;
    repeat (2) cyc();

    // Reset at idx 1 of 4, then a fresh instruction
    present(64'h99, 2'd3);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    present(64'hBEEF, 2'd2);
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();

    // Random traffic with occasional flush
    for (int n = 0; n < 300; n++) begin
      bus.in_valid    = ($urandom_range(0, 2) != 0);
      bus.in_cs       = {$urandom(), $urandom()};
      bus.in_last_idx = UOP_W'($urandom_range(0, 3));
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      cyc();
    end

    // Drain
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
